// File: rtl/vixen_l2_req_arbiter.sv
// Round-robin arbiter: I-cache and D-cache miss requests share the single L2 request channel.
// Latency: grant edge -> l2_req next cycle; l2_ack edge -> requester ack next cycle (min 2 + L2 latency).
// Backpressure: one transaction at a time; losing/late requesters hold req level until their ack pulse.
module vixen_l2_req_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_we,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    output logic              l2_we,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  perf_i_grants,
    output logic [CNT_W-1:0]  perf_d_grants,
    output logic [CNT_W-1:0]  perf_timeouts
);

    localparam int            TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_done;
    logic                w_timeout;

    logic                r_last_d;
    logic                r_side_d;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_l2_req;
    logic [ADDR_W-1:0]   r_l2_addr;
    logic [DATA_W-1:0]   r_l2_wdata;
    logic                r_l2_we;
    logic                r_i_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_perf_i;
    logic [CNT_W-1:0]    r_perf_d;
    logic [CNT_W-1:0]    r_perf_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_last_d=1 means D won the previous grant, so I wins the next tie.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_i = i_req && (!d_req || r_last_d);
                w_grant_d = d_req && !w_grant_i;
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (l2_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d   <= 1'b1;
            r_side_d   <= 1'b0;
            r_to_cnt   <= '0;
            r_l2_req   <= 1'b0;
            r_l2_addr  <= '0;
            r_l2_wdata <= '0;
            r_l2_we    <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
            r_perf_i   <= '0;
            r_perf_d   <= '0;
            r_perf_to  <= '0;
        end else begin
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_err     <= 1'b0;

            if (w_grant_i || w_grant_d) begin
                r_side_d   <= w_grant_d;
                r_last_d   <= w_grant_d;
                r_to_cnt   <= '0;
                r_l2_req   <= 1'b1;
                r_l2_addr  <= w_grant_d ? d_addr : i_addr;
                r_l2_wdata <= w_grant_d ? d_wdata : '0;
                r_l2_we    <= w_grant_d && d_we;
                if (w_grant_d) begin
                    r_perf_d <= r_perf_d + CNT_W'(1);
                end else begin
                    r_perf_i <= r_perf_i + CNT_W'(1);
                end
            end

            if (r_state == S_ISSUE) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            // A timed-out completion returns zero data with err set.
            if (w_done || w_timeout) begin
                r_l2_req <= 1'b0;
                r_err    <= w_timeout;
                if (r_side_d) begin
                    r_d_ack   <= 1'b1;
                    r_d_rdata <= w_done ? l2_rdata : '0;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_done ? l2_rdata : '0;
                end
                if (w_timeout) begin
                    r_perf_to <= r_perf_to + CNT_W'(1);
                end
            end
        end
    end

    assign i_ack         = r_i_ack;
    assign i_rdata       = r_i_rdata;
    assign d_ack         = r_d_ack;
    assign d_rdata       = r_d_rdata;
    assign err           = r_err;
    assign l2_req        = r_l2_req;
    assign l2_addr       = r_l2_addr;
    assign l2_wdata      = r_l2_wdata;
    assign l2_we         = r_l2_we;
    assign busy          = (r_state != S_IDLE);
    assign perf_i_grants = r_perf_i;
    assign perf_d_grants = r_perf_d;
    assign perf_timeouts = r_perf_to;

endmodule

// File: tb/tb_vixen_l2_req_arbiter.sv
// Directed bench for vixen_l2_req_arbiter: per-cycle vector table plus hand sequences
// for timeout, ack-at-timeout-limit and asynchronous reset mid-transaction.
module tb_vixen_l2_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 8;
    localparam int CW = 16;

    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;
    localparam logic [DW-1:0] Z     = '0;
    localparam logic [DW-1:0] PAT_A = {4{32'hA5A5_0001}};
    localparam logic [DW-1:0] PAT_B = {4{32'hB0B0_1234}};
    localparam logic [DW-1:0] PAT_C = {4{32'hC3C3_5678}};
    localparam logic [DW-1:0] PAT_D = {4{32'hD1D1_0F0F}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_we = 1'b0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          l2_req;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_wdata;
    logic          l2_we;
    logic [DW-1:0] l2_rdata = '0;
    logic          l2_ack = 1'b0;
    logic          busy;
    logic [CW-1:0] perf_i_grants;
    logic [CW-1:0] perf_d_grants;
    logic [CW-1:0] perf_timeouts;

    int checks = 0;
    int errors = 0;

    vixen_l2_req_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_we(l2_we),
        .l2_rdata(l2_rdata), .l2_ack(l2_ack), .busy(busy),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_timeouts(perf_timeouts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          i_req;
        logic          d_req;
        logic [AW-1:0] i_addr;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          d_we;
        logic          l2_ack;
        logic [DW-1:0] l2_rdata;
        logic          e_l2_req;
        logic [AW-1:0] e_l2_addr;
        logic          e_l2_we;
        logic [DW-1:0] e_l2_wdata;
        logic          e_i_ack;
        logic [DW-1:0] e_i_rdata;
        logic          e_d_ack;
        logic [DW-1:0] e_d_rdata;
        logic          e_err;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ir, input logic dr, input logic [AW-1:0] ia, input logic [AW-1:0] da,
        input logic [DW-1:0] dwd, input logic dwe, input logic ack, input logic [DW-1:0] rd,
        input logic el2, input logic [AW-1:0] eaddr, input logic ewe, input logic [DW-1:0] ewd,
        input logic eia, input logic [DW-1:0] eird, input logic eda, input logic [DW-1:0] edrd,
        input logic eerr, input logic ebusy);
        vec_t v;
        v.i_req = ir;  v.d_req = dr;  v.i_addr = ia;  v.d_addr = da;
        v.d_wdata = dwd;  v.d_we = dwe;  v.l2_ack = ack;  v.l2_rdata = rd;
        v.e_l2_req = el2;  v.e_l2_addr = eaddr;  v.e_l2_we = ewe;  v.e_l2_wdata = ewd;
        v.e_i_ack = eia;  v.e_i_rdata = eird;  v.e_d_ack = eda;  v.e_d_rdata = edrd;
        v.e_err = eerr;  v.e_busy = ebusy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".i_ack"},    i_ack, Z);
        chk({tag, ".d_ack"},    d_ack, Z);
        chk({tag, ".i_rdata"},  i_rdata, Z);
        chk({tag, ".d_rdata"},  d_rdata, Z);
        chk({tag, ".err"},      err, Z);
        chk({tag, ".l2_req"},   l2_req, Z);
        chk({tag, ".l2_addr"},  l2_addr, Z);
        chk({tag, ".l2_wdata"}, l2_wdata, Z);
        chk({tag, ".l2_we"},    l2_we, Z);
        chk({tag, ".busy"},     busy, Z);
        chk({tag, ".perf_i"},   perf_i_grants, Z);
        chk({tag, ".perf_d"},   perf_d_grants, Z);
        chk({tag, ".perf_to"},  perf_timeouts, Z);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [DW-1:0] r;
        logic sd;
        int got;
        logic got_err;
        logic [DW-1:0] got_rdata;

        // I read at 0x1000, L2 acks on the third ISSUE cycle with PAT_A.
        vecs.push_back(mk(L1,L0,32'h1000,'0,Z,L0, L0,Z, L1,32'h1000,L0,Z, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L1,L0,32'h1000,'0,Z,L0, L0,Z, L1,32'h1000,L0,Z, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L1,L0,32'h1000,'0,Z,L0, L0,Z, L1,32'h1000,L0,Z, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L1,L0,32'h1000,'0,Z,L0, L1,PAT_A, L0,'0,L0,Z, L1,PAT_A,L0,Z,L0,L1));
        vecs.push_back(mk(L0,L0,'0,'0,Z,L0, L0,Z, L0,'0,L0,Z, L0,Z,L0,Z,L0,L0));
        // D write at 0x2040; D inputs toggle and i_req rises during ISSUE, latched values hold.
        vecs.push_back(mk(L0,L1,'0,32'h2040,PAT_B,L1, L0,Z, L1,32'h2040,L1,PAT_B, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L1,L1,32'h1111,32'hDEAD,PAT_C,L0, L0,Z, L1,32'h2040,L1,PAT_B, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L1,L1,32'h1111,32'hBEEF,Z,L0, L0,Z, L1,32'h2040,L1,PAT_B, L0,Z,L0,Z,L0,L1));
        vecs.push_back(mk(L0,L1,'0,32'h2040,PAT_B,L1, L1,PAT_C, L0,'0,L0,Z, L0,Z,L1,PAT_C,L0,L1));
        vecs.push_back(mk(L0,L0,'0,'0,Z,L0, L0,Z, L0,'0,L0,Z, L0,Z,L0,Z,L0,L0));
        // Both requesters held high: grants alternate I,D,I,D,I,D, L2 acks immediately.
        for (int k = 0; k < 6; k++) begin
            sd = (k % 2) != 0;
            w  = 32'h5000_0000 + 32'(k);
            r  = {4{w}};
            vecs.push_back(mk(L1,L1,32'h3000,32'h4000,PAT_D,L1, L0,Z,
                              L1, sd ? 32'h4000 : 32'h3000, sd, sd ? PAT_D : Z,
                              L0,Z,L0,Z,L0,L1));
            vecs.push_back(mk(L1,L1,32'h3000,32'h4000,PAT_D,L1, L1,r,
                              L0,'0,L0,Z, !sd, sd ? Z : r, sd, sd ? r : Z, L0,L1));
            vecs.push_back(mk(L1,L1,32'h3000,32'h4000,PAT_D,L1, L0,Z,
                              L0,'0,L0,Z, L0,Z,L0,Z,L0,L0));
        end
        // Stray l2_ack in IDLE is ignored.
        vecs.push_back(mk(L0,L0,'0,'0,Z,L0, L1,PAT_A, L0,'0,L0,Z, L0,Z,L0,Z,L0,L0));
        vecs.push_back(mk(L0,L0,'0,'0,Z,L0, L0,Z, L0,'0,L0,Z, L0,Z,L0,Z,L0,L0));

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            i_req = vecs[i].i_req;  d_req = vecs[i].d_req;
            i_addr = vecs[i].i_addr;  d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata;  d_we = vecs[i].d_we;
            l2_ack = vecs[i].l2_ack;  l2_rdata = vecs[i].l2_rdata;
            tick();
            chk($sformatf("v%0d.l2_req", i),  l2_req,  vecs[i].e_l2_req);
            chk($sformatf("v%0d.i_ack", i),   i_ack,   vecs[i].e_i_ack);
            chk($sformatf("v%0d.i_rdata", i), i_rdata, vecs[i].e_i_rdata);
            chk($sformatf("v%0d.d_ack", i),   d_ack,   vecs[i].e_d_ack);
            chk($sformatf("v%0d.d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            chk($sformatf("v%0d.err", i),     err,     vecs[i].e_err);
            chk($sformatf("v%0d.busy", i),    busy,    vecs[i].e_busy);
            if (vecs[i].e_l2_req) begin
                chk($sformatf("v%0d.l2_addr", i),  l2_addr,  vecs[i].e_l2_addr);
                chk($sformatf("v%0d.l2_we", i),    l2_we,    vecs[i].e_l2_we);
                chk($sformatf("v%0d.l2_wdata", i), l2_wdata, vecs[i].e_l2_wdata);
            end
        end
        chk("perf_i_after_table", perf_i_grants, 4);
        chk("perf_d_after_table", perf_d_grants, 4);
        chk("perf_to_after_table", perf_timeouts, 0);

        // Timeout: no l2_ack, ack/err expected TO edges after the grant edge.
        @(negedge clk);
        i_req = 1'b1;  i_addr = 32'h6000;
        tick();
        chk("to_grant.l2_req", l2_req, 1);
        got = -1;
        got_err = 1'b0;
        got_rdata = PAT_A;
        for (int k = 1; k <= 3 * TO && got < 0; k++) begin
            tick();
            if (i_ack || d_ack) begin
                got = k;
                got_err = err;
                got_rdata = i_rdata;
                chk("to_ack_side", d_ack, 0);
                chk("to_l2_req_drop", l2_req, 0);
            end
        end
        chk("to_latency", got, TO);
        chk("to_err", got_err, 1);
        chk("to_rdata", got_rdata, Z);
        @(negedge clk);
        i_req = 1'b0;
        tick();
        chk("to_idle.busy", busy, 0);
        chk("to_idle.i_ack", i_ack, 0);
        chk("perf_timeouts", perf_timeouts, 1);
        @(negedge clk);
        l2_ack = 1'b1;  l2_rdata = PAT_A;
        tick();
        @(negedge clk);
        l2_ack = 1'b0;  l2_rdata = Z;
        chk("late_ack.i_ack", i_ack, 0);
        chk("late_ack.busy", busy, 0);
        tick();
        chk("late_ack2.i_ack", i_ack, 0);
        chk("late_ack2.d_ack", d_ack, 0);

        // l2_ack exactly on the timeout-limit edge is a normal completion.
        @(negedge clk);
        i_req = 1'b1;  i_addr = 32'h7000;
        tick();
        for (int k = 1; k < TO; k++) begin
            tick();
        end
        chk("coinc_pre.i_ack", i_ack, 0);
        @(negedge clk);
        l2_ack = 1'b1;  l2_rdata = PAT_C;
        tick();
        chk("coinc.i_ack", i_ack, 1);
        chk("coinc.err", err, 0);
        chk("coinc.i_rdata", i_rdata, PAT_C);
        @(negedge clk);
        l2_ack = 1'b0;  l2_rdata = Z;  i_req = 1'b0;
        tick();
        chk("coinc_idle.busy", busy, 0);
        chk("coinc.perf_to", perf_timeouts, 1);

        // Reset in the middle of ISSUE; the pointer was last=I, reset returns it to D.
        @(negedge clk);
        i_req = 1'b1;  i_addr = 32'h8000;
        tick();
        tick();
        chk("rst_pre.l2_req", l2_req, 1);
        #2;
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        chk("rst_async.l2_req", l2_req, 0);
        chk("rst_async.busy", busy, 0);
        chk_reset_outputs("rst_mid");
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("rst_hold%0d.i_ack", k), i_ack, 0);
            chk($sformatf("rst_hold%0d.d_ack", k), d_ack, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b1;  d_req = 1'b1;
        i_addr = 32'h9000;  d_addr = 32'hA000;  d_wdata = PAT_D;  d_we = 1'b1;
        tick();
        chk("rst_tie.l2_req", l2_req, 1);
        chk("rst_tie.l2_addr", l2_addr, 32'h9000);
        chk("rst_tie.l2_we", l2_we, 0);
        chk("rst_tie.l2_wdata", l2_wdata, Z);
        chk("rst_tie.perf_i", perf_i_grants, 1);
        chk("rst_tie.perf_d", perf_d_grants, 0);
        @(negedge clk);
        i_req = 1'b0;  d_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vixen_l2_req_arbiter.md
# vixen_l2_req_arbiter

Sequencing arbiter between the L1 I-cache and L1 D-cache miss paths and the single request channel of the shared L2 cache. Accepts one request at a time from either side with round-robin fairness and latches its address and write data. It then drives the L2 request until acknowledged and routes the response back to the winning requester. A per-transaction timeout guarantees forward progress if the L2 never acknowledges.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 512, cache-line data width
- TIMEOUT_CYCLES, 64, max cycles in ISSUE before forced completion; 0 disables the timeout
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-side request, level
- i_addr  in  ADDR_W  I-side line address
- i_ack  out  1  I-side completion, one-cycle pulse
- i_rdata  out  DATA_W  I-side fill data, valid with i_ack
- d_req  in  1  D-side request, level
- d_addr  in  ADDR_W  D-side line address
- d_wdata  in  DATA_W  D-side write data
- d_we  in  1  D-side write enable
- d_ack  out  1  D-side completion, one-cycle pulse
- d_rdata  out  DATA_W  D-side read data, valid with d_ack
- err  out  1  completion was a timeout; valid with i_ack/d_ack
- l2_req  out  1  L2 request, held until l2_ack
- l2_addr  out  ADDR_W  latched address
- l2_wdata  out  DATA_W  latched write data; 0 for I-side
- l2_we  out  1  latched write enable; 0 for I-side
- l2_rdata  in  DATA_W  L2 response data, sampled with l2_ack
- l2_ack  in  1  L2 completion, one-cycle pulse
- busy  out  1  FSM not in IDLE
- perf_i_grants  out  CNT_W  I-side grants
- perf_d_grants  out  CNT_W  D-side grants
- perf_timeouts  out  CNT_W  timed-out transactions

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if no request is present, stay in IDLE.
  - If exactly one request is present, grant that side.
  - If both are present, grant the side not granted last. The round-robin pointer resets to "last = D", so I wins the first tie.
  - On grant, latch side, address, d_wdata/d_we (D) or 0/0 (I), update the pointer, increment the side's grant counter, and go to ISSUE.
- ISSUE: l2_req=1 with latched l2_addr/l2_wdata/l2_we, stable for the whole state. Inputs changing during ISSUE have no effect.
  - On l2_ack: latch l2_rdata, set err=0, go to RESP.
  - Otherwise, if TIMEOUT_CYCLES≠0 and the ISSUE cycle count reaches TIMEOUT_CYCLES: latch data 0, set err=1, increment perf_timeouts, go to RESP.
  - l2_ack in the same cycle as the timeout limit counts as a normal ack.
- RESP: for one cycle, the granted side's ack=1 with its rdata and err. The other side's ack and rdata stay 0. Then go to IDLE.
- Requester contract: a requester drops req in the cycle its ack is high. A req still high in the following IDLE cycle is a new request.
- l2_ack received in IDLE or RESP is ignored.
- Counters wrap modulo 2^CNT_W.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous): state=IDLE, pointer=D. All outputs 0: i_ack, d_ack, i_rdata, d_rdata, err, l2_req, l2_addr, l2_wdata, l2_we, busy, all perf counters.
- Reset mid-transaction: l2_req drops immediately and the transaction is abandoned; no ack is delivered.
- Request seen in IDLE at edge N → l2_req high from cycle N+1.
- l2_ack sampled at edge M → requester ack high during cycle M+1, and l2_req is low in that cycle.
- Minimum request-to-ack latency: 2 cycles plus L2 latency. Back-to-back grants are separated by one IDLE cycle, so throughput is at most 1 transaction per 3 cycles.
- Timeout: if the request is granted at edge N with no ack, the ack/err pulse is high in cycle N+TIMEOUT_CYCLES+1.
- All outputs are registered.

## Test plan
- Single I read, addr 0x1000, L2 acks after 3 cycles with data pattern A:
  - l2_req high for 3 cycles, l2_we=0, l2_wdata=0.
  - i_ack for one cycle with i_rdata=A, err=0.
  - perf_i_grants=1.
- D write, addr 0x2040, we=1, wdata=B:
  - l2_addr=0x2040, l2_we=1, l2_wdata=B held stable while d_addr is toggled during ISSUE.
  - d_ack after l2_ack; i_ack stays 0.
- i_req and d_req held high continuously for 6 transactions:
  - Grant order I,D,I,D,I,D.
  - perf_i_grants=3, perf_d_grants=3.
- TIMEOUT_CYCLES=8, l2_ack never asserted:
  - Ack pulse with err=1 and rdata=0, exactly 9 cycles after grant.
  - perf_timeouts=1; a later l2_ack in IDLE produces no ack.
- Assert rst_n=0 in the middle of ISSUE:
  - l2_req and busy drop without a clock edge; no ack is produced.
  - After release, a tie is granted to I.
- l2_ack coincident with the timeout limit → err=0 and rdata equals l2_rdata.
